// File: rtl/hazard_dispatcher.sv
// rtl/hazard_dispatcher.sv - dependency-aware dispatcher from one fetch stream to NUM_CORES in-order cores
module hazard_dispatcher #(
  parameter int NUM_CORES = 2,
  parameter int DEPTH     = 8,
  parameter int INSTR_W   = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [INSTR_W-1:0]                     in_instr,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [NUM_CORES*INSTR_W-1:0]           out_instr,
  output logic [NUM_CORES-1:0]                   out_valid,
  input  logic [NUM_CORES-1:0]                   out_ready,
  input  logic [NUM_CORES-1:0]                   retire,
  output logic [NUM_CORES*$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  // Per-core circular queues.
  logic [INSTR_W-1:0] mem    [NUM_CORES][DEPTH];
  logic [AW-1:0]      rd_ptr [NUM_CORES];
  logic [AW-1:0]      wr_ptr [NUM_CORES];
  logic [CW-1:0]      cnt    [NUM_CORES];

  // In-flight register per core; only the operand keys matter once popped.
  logic [11:0]          infl_src [NUM_CORES];
  logic [11:0]          infl_dst [NUM_CORES];
  logic [NUM_CORES-1:0] infl_valid;

  logic [PW-1:0]        rr_ptr;

  logic [NUM_CORES-1:0] hit;
  logic [NUM_CORES-1:0] full;
  logic [NUM_CORES-1:0] pop;
  logic [NUM_CORES-1:0] push;
  logic [PW-1:0]        target;
  logic                 sel_ok;
  logic                 sel_nohit;
  logic                 accept;

  logic [11:0]          new_src;
  logic [11:0]          new_dst;

  function automatic logic [11:0] src_key(input logic [INSTR_W-1:0] x);
    return {x[23], x[10:0]};
  endfunction

  function automatic logic [11:0] dst_key(input logic [INSTR_W-1:0] x);
    return {x[22], x[21:11]};
  endfunction

  // RAW, WAR or WAW between the incoming instruction and one tracked entry.
  function automatic logic conflict(input logic [11:0] n_src, input logic [11:0] n_dst,
                                    input logic [11:0] e_src, input logic [11:0] e_dst);
    return (n_src == e_dst) || (n_dst == e_src) || (n_dst == e_dst);
  endfunction

  assign new_src = src_key(in_instr);
  assign new_dst = dst_key(in_instr);

  // Hazard scan of every live queue slot and in-flight register, using pre-edge state.
  always_comb begin
    logic [AW-1:0] off;
    hit = '0;
    off = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = AW'(i) - rd_ptr[c];
        if ((CW'(off) < cnt[c]) &&
            conflict(new_src, new_dst, src_key(mem[c][i]), dst_key(mem[c][i]))) begin
          hit[c] = 1'b1;
        end
      end
      if (infl_valid[c] && conflict(new_src, new_dst, infl_src[c], infl_dst[c])) begin
        hit[c] = 1'b1;
      end
    end
  end

  // Target choice: single hit steers, multiple hits stall, no hit goes round-robin.
  always_comb begin
    int n_hits;
    int best_d;
    int d;
    logic hit_full;
    logic [PW-1:0] hit_idx;
    n_hits    = 0;
    best_d    = NUM_CORES;
    d         = 0;
    hit_full  = 1'b0;
    hit_idx   = '0;
    target    = '0;
    sel_ok    = 1'b0;
    sel_nohit = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      full[c] = (cnt[c] == CW'(DEPTH));
    end
    for (int c = 0; c < NUM_CORES; c++) begin
      if (hit[c]) begin
        n_hits   = n_hits + 1;
        hit_idx  = PW'(c);
        hit_full = full[c];
      end
    end
    if (n_hits == 0) begin
      sel_nohit = 1'b1;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (!full[c]) begin
          d = (c - int'(rr_ptr) + NUM_CORES) % NUM_CORES;
          if (d < best_d) begin
            best_d = d;
            target = PW'(c);
          end
        end
      end
      sel_ok = (best_d < NUM_CORES);
    end else if (n_hits == 1) begin
      target = hit_idx;
      sel_ok = !hit_full;
    end
  end

  assign in_ready = in_valid ? sel_ok : ~(&full);
  assign accept   = in_valid && sel_ok;

  // Per-core handshake decode and registered-state views on the outputs.
  always_comb begin
    out_instr = '0;
    q_count   = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      out_valid[c] = (cnt[c] != '0);
      pop[c]       = out_valid[c] && out_ready[c];
      push[c]      = accept && (target == PW'(c));
      if (out_valid[c]) begin
        out_instr[c*INSTR_W +: INSTR_W] = mem[c][rd_ptr[c]];
      end
      q_count[c*CW +: CW] = cnt[c];
    end
  end

  // Queue storage, pointers, counts, in-flight tracking and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      infl_valid <= '0;
      rr_ptr     <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (push[c]) begin
          mem[c][wr_ptr[c]] <= in_instr;
          wr_ptr[c]         <= wr_ptr[c] + 1'b1;
        end
        if (pop[c]) begin
          rd_ptr[c]     <= rd_ptr[c] + 1'b1;
          infl_src[c]   <= src_key(mem[c][rd_ptr[c]]);
          infl_dst[c]   <= dst_key(mem[c][rd_ptr[c]]);
          infl_valid[c] <= 1'b1;
        end else if (retire[c]) begin
          infl_valid[c] <= 1'b0;
        end
        if (push[c] && !pop[c]) begin
          cnt[c] <= cnt[c] + CW'(1);
        end else if (!push[c] && pop[c]) begin
          cnt[c] <= cnt[c] - CW'(1);
        end
      end
      if (accept && sel_nohit) begin
        rr_ptr <= (target == PW'(NUM_CORES - 1)) ? '0 : target + 1'b1;
      end
    end
  end

endmodule

// File: doc/hazard_dispatcher.md
# hazard_dispatcher

- Parametrised dependency-aware instruction dispatcher between the fetch stream and `NUM_CORES` in-order execution cores.
- Buffers instructions in one bounded queue per core.
- Detects operand hazards against everything queued or in flight, across all cores, and steers each dependent instruction to the core that already owns the conflicting work.
- Spreads independent instructions round-robin; stalls the fetch stream only when a hazard spans several cores or the required queue is full.

## Interface
- `NUM_CORES`, 2: number of cores and queues; ≥2.
- `DEPTH`, 8: entries per core queue; power of two, ≥2.
- `INSTR_W`, 32: instruction width; ≥24.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_instr` input INSTR_W: instruction from fetch.
- `in_valid` input 1: `in_instr` valid.
- `in_ready` output 1: dispatcher accepts `in_instr` this cycle (combinational).
- `out_instr` output NUM_CORES*INSTR_W: head of queue c at bits [c*INSTR_W +: INSTR_W].
- `out_valid` output NUM_CORES: queue c non-empty.
- `out_ready` input NUM_CORES: core c pops its head this cycle.
- `retire` input NUM_CORES: one-cycle pulse; core c finished its in-flight instruction.
- `q_count` output NUM_CORES*$clog2(DEPTH+1): occupancy of queue c.

## Operation
- Operand keys: src = {instr[23], instr[10:0]}, dst = {instr[22], instr[21:11]}. Both keys are 12 bits, flag bit included in every compare.
- Tracked set of core c: all valid entries of queue c, plus in-flight register c (last popped instruction, valid until `retire[c]`).
- Hazard of new instruction N vs tracked entry E, any of:
  - N.src == E.dst (RAW)
  - N.dst == E.src (WAR)
  - N.dst == E.dst (WAW)
- `hit[c]` = N hazards with any entry in the tracked set of core c.
- Target selection while `in_valid`:
  - More than one `hit` bit set: stall; `in_ready`=0.
  - Exactly one `hit[c]`: target c. Stall if queue c is full.
  - No hits: first non-full queue searching from `rr_ptr` upward, wrapping. Stall if all queues are full.
- Accept when `in_valid && in_ready`: push to target tail.
  - On a no-hit accept only, `rr_ptr` becomes (target+1) mod NUM_CORES.
  - `rr_ptr` is unchanged on hit-steered accepts.
- `in_ready` with `in_valid`=0: 1 if any queue is non-full.
- Pop when `out_valid[c] && out_ready[c]`:
  - Head is removed.
  - Head is copied into in-flight register c; in-flight c becomes valid.
  - `out_ready` with `out_valid`=0 is ignored.
- `retire[c]` clears in-flight c.
  - Same-cycle pop and retire on c: the newly popped instruction stays in flight (pop wins).
- Conservative rules:
  - Fullness and hazard evaluation use state before this cycle's pops/retires.
  - A push to a full queue with a simultaneous pop is refused.
  - Entries being popped/retired this cycle still count as hazards.
- Simultaneous push and pop on a non-full queue: both take effect; count unchanged.
- Queues are circular buffers; read and write pointers wrap at DEPTH.
- Reset values:
  - All counts 0, `out_valid`=0, `out_instr`=0.
  - All in-flight registers invalid, `rr_ptr`=0.
  - `in_ready`=1 in the first cycle after reset.
- `rst` mid-operation: all queued and in-flight contents are discarded; no partial dispatch.

## Timing
- `in_ready` is combinational from `in_instr`, queue and in-flight state. No combinational path from `out_ready` or `retire` to `in_ready`.
- Push latency: accepted at edge k; `out_valid[c]`=1 with that instruction at head after edge k (cycle k+1) if the queue was empty.
- Pop: the head advances at the edge where `out_valid && out_ready`.
- Hazard release: a conflict is cleared the cycle after the edge that samples `retire`.
- `q_count`, `out_valid` and `out_instr` are registered.
- One instruction is accepted per cycle at most; each core pops one per cycle at most.

## Test plan
- Round-robin:
  - Stimulus: reset, then push 4 independent instructions (dst 0x001..0x004, src 0x7F0..0x7F3, flags 0), out_ready=0.
  - Response: queue0 gets #1, #3; queue1 gets #2, #4; q_count = 2, 2.
- RAW steering:
  - Stimulus: push A (dst 0x010) → core0. Push B (src 0x010).
  - Response: B goes to core0 even though `rr_ptr`=1; `rr_ptr` stays 1.
- Cross-core stall:
  - Stimulus: A (dst 0x020) in core0, B (dst 0x030) in core1. Push C (src 0x020, dst 0x030).
  - Response: `in_ready`=0.
  - Then pop A, pulse `retire[0]`: C is accepted into core1 on the following cycle.
- Full queue:
  - Stimulus: DEPTH hazard-chained instructions fill core0; one more dependent instruction arrives.
  - Response: `in_ready`=0 while full, including a same-cycle pop.
  - Accepted the cycle after the pop; q_count never exceeds DEPTH.
- Pop+retire same cycle:
  - Stimulus: X in flight on core1, Y queued; `out_ready[1]` and `retire[1]` asserted together.
  - Response: Y is in flight; an instruction dependent on Y steers to core1.
- Reset mid-stream:
  - Stimulus: assert `rst` with all queues partly full.
  - Response: next cycle all counts 0, `out_valid`=0, `in_ready`=1, the next independent instruction goes to core0.
